// File: rtl/counter_param.sv
// counter_param: parametrised up/down counter, wrap or saturate mode,
// synchronous clear, optional clamped parallel load, registered tc pulse.
// Ports: clk, rst (sync, active high), en, up, sat, clear,
//   load/load_val (only with COUNTER_PARAM_LOAD_EN), count, tc.
// Macro COUNTER_PARAM_LOAD_EN adds the load/load_val ports and load path.
module counter_param #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             clear,
`ifdef COUNTER_PARAM_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // Bounds held one bit wider so MODULUS = 2^WIDTH compares correctly.
  localparam logic [WIDTH:0]   MAX = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic [WIDTH:0]   cext;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] step_cnt;
  logic             step_tc;

  assign cext   = {1'b0, count};
  assign at_top = (cext >= MAX);
  assign at_bot = (cext == '0);

  always_comb begin
    step_cnt = count;
    step_tc  = 1'b0;
    if (up) begin
      if (!at_top) begin
        step_cnt = count + 1'b1;
      end else begin
        step_tc  = 1'b1;
        step_cnt = sat ? TOP : '0;
      end
    end else begin
      if (!at_bot) begin
        step_cnt = count - 1'b1;
      end else begin
        step_tc  = 1'b1;
        step_cnt = sat ? '0 : TOP;
      end
    end
  end

`ifdef COUNTER_PARAM_LOAD_EN
  logic [WIDTH-1:0] load_clamped;
  assign load_clamped = ({1'b0, load_val} > MAX) ? TOP : load_val;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tc    <= 1'b0;
`ifdef COUNTER_PARAM_LOAD_EN
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
`endif
    end else if (en) begin
      count <= step_cnt;
      tc    <= step_tc;
    end else begin
      tc    <= 1'b0;
    end
  end

endmodule
